// File: rtl/npc_seq_pkg.sv
// npc_seq_pkg: shared constants for the next-PC sequencer.
//   - NPC_* operation codes driven by the decoder.
//   - FSM state encodings (BOOT/RUN/TRAP/HALT).
//   - Default reset and trap vectors.
//   - word_misaligned(): 4-byte alignment test on a target's low bits.
package npc_seq_pkg;

    localparam logic [2:0] NPC_PLUS4  = 3'b000;
    localparam logic [2:0] NPC_BRANCH = 3'b001;
    localparam logic [2:0] NPC_JUMP   = 3'b010;
    localparam logic [2:0] NPC_JALR   = 3'b100;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_TRAP = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

    function automatic logic word_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/npc_seq_if.sv
// npc_seq_if: bundle between the control path and the next-PC sequencer.
//   master (control side) drives: stall, halt, resume, trap_req, npc_op,
//     imm, rs1, is_call, is_ret
//   slave (npc_seq) drives: pc, pc_valid, misalign, epc, ras_top,
//     ras_mispred_cnt
interface npc_seq_if #(
    parameter int XLEN = 32
);
    logic            stall;
    logic            halt;
    logic            resume;
    logic            trap_req;
    logic [2:0]      npc_op;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] rs1;
    logic            is_call;
    logic            is_ret;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic            misalign;
    logic [XLEN-1:0] epc;
    logic [XLEN-1:0] ras_top;
    logic [31:0]     ras_mispred_cnt;

    modport master (
        output stall, halt, resume, trap_req, npc_op, imm, rs1, is_call, is_ret,
        input  pc, pc_valid, misalign, epc, ras_top, ras_mispred_cnt
    );

    modport slave (
        input  stall, halt, resume, trap_req, npc_op, imm, rs1, is_call, is_ret,
        output pc, pc_valid, misalign, epc, ras_top, ras_mispred_cnt
    );
endinterface

// File: rtl/npc_seq_ras.sv
// npc_seq_ras: circular return-address stack (only built with NPC_RAS_EN).
//   clk, rst   : clock, async active-high reset (empties the stack)
//   push, pop  : push din / pop top; both together replace the top entry
//   din        : return address to push
//   top        : top entry, 0 when empty
//   empty, full: occupancy flags
// Pushing when full overwrites the oldest entry; popping when empty is a no-op.
`ifdef NPC_RAS_EN
module npc_seq_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] din,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   ptr_inc;
    logic [PW:0]     cnt;
    logic            do_push;
    logic            do_pop;
    logic            do_replace;

    assign empty      = (cnt == '0);
    assign full       = (cnt == (PW+1)'(DEPTH));
    assign ptr_inc    = ptr + 1'b1;
    // pop+push on an empty stack degenerates to a plain push
    assign do_replace = push && pop && !empty;
    assign do_push    = push && !do_replace;
    assign do_pop     = pop && !push && !empty;
    assign top        = empty ? '0 : mem[ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (do_push) begin
            ptr <= ptr_inc;
            if (!full) cnt <= cnt + 1'b1;
        end else if (do_pop) begin
            ptr <= ptr - 1'b1;
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)         mem[ptr_inc] <= din;
        else if (do_replace) mem[ptr]     <= din;
    end
endmodule
`endif

// File: rtl/npc_seq.sv
// npc_seq: registered next-PC generator owning the PC register.
//   clk, rst : clock, async active-high reset
//   bus      : npc_seq_if slave (control inputs, pc/epc/status outputs)
// Optional macro NPC_RAS_EN adds a return-address stack and a saturating
// return-mispredict counter; without it ras_top and ras_mispred_cnt are 0.
//
// state | meaning
// BOOT  | first cycle after reset, pc not yet fetchable
// RUN   | pc valid, advances to the computed target each accepted cycle
// TRAP  | trap taken, pc loads TRAP_VEC on the next edge
// HALT  | pc frozen until resume
import npc_seq_pkg::*;

module npc_seq #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
    parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
    parameter int              RAS_DEPTH = 4
) (
    input logic     clk,
    input logic     rst,
    npc_seq_if.slave bus
);
    logic [1:0]      state;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] epc_q;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] jalr_sum;
    logic [XLEN-1:0] pc_plus4;
    logic            accept;
    logic            mis;
    logic            upd;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign jalr_sum = bus.rs1 + bus.imm;

    always_comb begin
        target = pc_plus4;
        case (bus.npc_op)
            NPC_BRANCH, NPC_JUMP: target = pc_q + bus.imm;
            NPC_JALR:             target = {jalr_sum[XLEN-1:1], 1'b0};
            default:              target = pc_plus4;
        endcase
    end

    // accept: RUN with nothing of higher priority pending
    assign accept = (state == ST_RUN) && !bus.trap_req && !bus.halt && !bus.stall;
    assign mis    = accept && word_misaligned(target[1:0]);
    assign upd    = accept && !mis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
            pc_q  <= RESET_VEC;
            epc_q <= '0;
        end else begin
            case (state)
                ST_BOOT: state <= ST_RUN;
                ST_RUN: begin
                    if (bus.trap_req || mis) begin
                        epc_q <= pc_q;
                        state <= ST_TRAP;
                    end else if (bus.halt) begin
                        state <= ST_HALT;
                    end else if (upd) begin
                        pc_q <= target;
                    end
                end
                ST_TRAP: begin
                    pc_q  <= TRAP_VEC;
                    state <= ST_RUN;
                end
                default: if (bus.resume) state <= ST_RUN;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.epc      = epc_q;
    assign bus.pc_valid = (state == ST_RUN);
    assign bus.misalign = mis;

`ifdef NPC_RAS_EN
    logic [XLEN-1:0] ras_top_w;
    logic            ras_empty;
    logic            unused_ras_full;
    logic [31:0]     mispred_q;

    npc_seq_ras #(.XLEN(XLEN), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (upd && bus.is_call),
        .pop   (upd && bus.is_ret),
        .din   (pc_plus4),
        .top   (ras_top_w),
        .empty (ras_empty),
        .full  (unused_ras_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_q <= '0;
        end else if (upd && bus.is_ret && !ras_empty &&
                     (ras_top_w != target) && (mispred_q != '1)) begin
            mispred_q <= mispred_q + 32'd1;
        end
    end

    assign bus.ras_top         = ras_top_w;
    assign bus.ras_mispred_cnt = mispred_q;
`else
    logic unused_ras_hints;
    assign unused_ras_hints    = bus.is_call ^ bus.is_ret ^ (RAS_DEPTH == 0);
    assign bus.ras_top         = '0;
    assign bus.ras_mispred_cnt = '0;
`endif

endmodule

// File: tb/tb_npc_seq.sv
// tb_npc_seq: self-checking bench for npc_seq (table vectors + hand sequences).
import npc_seq_pkg::*;

module tb_npc_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    npc_seq_if #(.XLEN(32)) bus ();

    npc_seq #(.XLEN(32), .RESET_VEC(32'h0), .TRAP_VEC(32'h100), .RAS_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic [31:0] exp_pc;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs[8];
    logic [31:0] sb_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] imm, input logic [31:0] rs1);
        bus.npc_op = op;
        bus.imm    = imm;
        bus.rs1    = rs1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_pc;
        bus.stall = 0; bus.halt = 0; bus.resume = 0; bus.trap_req = 0;
        bus.is_call = 0; bus.is_ret = 0;
        drive(NPC_PLUS4, 32'h0, 32'h0);

        // pc chain starts at 0x8; each entry's expected pc follows from the previous
        vecs[0] = '{NPC_JUMP,   32'h0000_0008, 32'h0,          32'h0000_0010, 1'b0};
        vecs[1] = '{NPC_BRANCH, 32'hFFFF_FFF8, 32'h0,          32'h0000_0008, 1'b0};
        vecs[2] = '{NPC_JALR,   32'h0000_000C, 32'hFFFF_FFF0,  32'hFFFF_FFFC, 1'b0};
        vecs[3] = '{NPC_PLUS4,  32'h1234_5678, 32'h0,          32'h0000_0000, 1'b0};
        vecs[4] = '{3'b011,     32'h0000_0100, 32'h0,          32'h0000_0004, 1'b0};
        vecs[5] = '{3'b111,     32'h0000_0100, 32'h0000_0200,  32'h0000_0008, 1'b0};
        vecs[6] = '{NPC_JALR,   32'h0000_0000, 32'h0000_0025,  32'h0000_0024, 1'b0};
        vecs[7] = '{NPC_JUMP,   32'hFFFF_FFFC, 32'h0,          32'h0000_0020, 1'b0};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", bus.pc, 32'h0);
        chk("rst_pc_valid", 32'(bus.pc_valid), 32'h0);
        chk("rst_epc", bus.epc, 32'h0);
        chk("rst_misalign", 32'(bus.misalign), 32'h0);
        chk("rst_ras_top", bus.ras_top, 32'h0);
        chk("rst_mispred", bus.ras_mispred_cnt, 32'h0);
        rst = 0;
        chk("boot_pc", bus.pc, 32'h0);
        chk("boot_valid", 32'(bus.pc_valid), 32'h0);
        tick();
        chk("run0_pc", bus.pc, 32'h0);
        chk("run0_valid", 32'(bus.pc_valid), 32'h1);
        tick();
        chk("plus4_a", bus.pc, 32'h4);
        tick();
        chk("plus4_b", bus.pc, 32'h8);

        // table-driven target computation through a scoreboard
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].op, vecs[i].imm, vecs[i].rs1);
            sb_q.push_back(vecs[i].exp_pc);
            #1;
            chk($sformatf("vec%0d_misalign", i), 32'(bus.misalign), 32'(vecs[i].exp_mis));
            tick();
            if (sb_q.size() == 0) begin
                chk("sb_underflow", 32'h1, 32'h0);
            end else begin
                exp_pc = sb_q.pop_front();
                chk($sformatf("vec%0d_pc", i), bus.pc, exp_pc);
            end
        end

        // misaligned JALR at pc=0x20
        drive(NPC_JALR, 32'h0, 32'h103);
        #1;
        chk("mis_pulse", 32'(bus.misalign), 32'h1);
        tick();
        chk("mis_epc", bus.epc, 32'h20);
        chk("mis_pc_held", bus.pc, 32'h20);
        chk("mis_trap_valid", 32'(bus.pc_valid), 32'h0);
        chk("mis_pulse_gone", 32'(bus.misalign), 32'h0);
        drive(NPC_PLUS4, 32'h0, 32'h0);
        tick();
        chk("mis_trap_vec", bus.pc, 32'h100);
        chk("mis_run_valid", 32'(bus.pc_valid), 32'h1);

        // stall: go to pc=0x8 first
        drive(NPC_JUMP, 32'hFFFF_FF08, 32'h0);
        tick();
        chk("stall_setup", bus.pc, 32'h8);
        bus.stall = 1;
        drive(NPC_JUMP, 32'h2, 32'h0);
        #1;
        chk("stall_mis_suppr", 32'(bus.misalign), 32'h0);
        tick();
        chk("stall_mis_pc", bus.pc, 32'h8);
        drive(NPC_JUMP, 32'h40, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("stall_hold%0d", i), bus.pc, 32'h8);
        end
        bus.stall = 0;
        tick();
        chk("stall_release", bus.pc, 32'h48);
        drive(NPC_JUMP, 32'hFFFF_FFC0, 32'h0);
        tick();
        chk("stall_trap_setup", bus.pc, 32'h8);
        bus.stall = 1;
        bus.trap_req = 1;
        drive(NPC_JUMP, 32'h2, 32'h0);
        #1;
        chk("trap_no_misalign", 32'(bus.misalign), 32'h0);
        tick();
        bus.stall = 0;
        bus.trap_req = 0;
        drive(NPC_PLUS4, 32'h0, 32'h0);
        chk("stall_trap_epc", bus.epc, 32'h8);
        chk("stall_trap_valid", 32'(bus.pc_valid), 32'h0);
        tick();
        chk("stall_trap_vec", bus.pc, 32'h100);

        // halt at pc=0x30
        drive(NPC_JUMP, 32'hFFFF_FF30, 32'h0);
        tick();
        chk("halt_setup", bus.pc, 32'h30);
        bus.halt = 1;
        tick();
        bus.halt = 0;
        chk("halt_valid", 32'(bus.pc_valid), 32'h0);
        drive(NPC_JUMP, 32'h40, 32'h0);
        bus.trap_req = 1;
        repeat (2) tick();
        bus.trap_req = 0;
        chk("halt_hold_pc", bus.pc, 32'h30);
        chk("halt_hold_valid", 32'(bus.pc_valid), 32'h0);
        bus.halt = 1;
        bus.resume = 1;
        tick();
        bus.halt = 0;
        bus.resume = 0;
        chk("resume_valid", 32'(bus.pc_valid), 32'h1);
        chk("resume_pc", bus.pc, 32'h30);
        drive(NPC_PLUS4, 32'h0, 32'h0);
        tick();
        chk("resume_plus4", bus.pc, 32'h34);

        // trap_req beats halt
        bus.trap_req = 1;
        bus.halt = 1;
        tick();
        bus.trap_req = 0;
        bus.halt = 0;
        chk("trap_over_halt_epc", bus.epc, 32'h34);
        tick();
        chk("trap_over_halt_pc", bus.pc, 32'h100);
        chk("trap_over_halt_valid", 32'(bus.pc_valid), 32'h1);

        // async reset while halted
        bus.halt = 1;
        tick();
        bus.halt = 0;
        #2 rst = 1;
        #1;
        chk("async_rst_pc", bus.pc, 32'h0);
        chk("async_rst_valid", 32'(bus.pc_valid), 32'h0);
        chk("async_rst_epc", bus.epc, 32'h0);
        #1 rst = 0;
        tick();
        chk("post_rst_valid", 32'(bus.pc_valid), 32'h1);
        chk("post_rst_pc", bus.pc, 32'h0);

`ifdef NPC_RAS_EN
        // five calls into a depth-4 stack
        bus.is_call = 1;
        drive(NPC_JUMP, 32'h10, 32'h0);
        repeat (5) tick();
        bus.is_call = 0;
        chk("ras_top_5calls", bus.ras_top, 32'h44);
        chk("ras_call_pc", bus.pc, 32'h50);
        bus.is_ret = 1;
        drive(NPC_JALR, 32'h0, 32'h99C);
        tick();
        chk("ras_mispred1", bus.ras_mispred_cnt, 32'h1);
        chk("ras_ret_pc", bus.pc, 32'h99C);
        chk("ras_top_after_pop", bus.ras_top, 32'h34);
        drive(NPC_JALR, 32'h0, 32'h34);
        tick();
        chk("ras_top_pop2", bus.ras_top, 32'h24);
        drive(NPC_JALR, 32'h0, 32'h24);
        tick();
        chk("ras_top_pop3", bus.ras_top, 32'h14);
        drive(NPC_JALR, 32'h0, 32'h14);
        tick();
        chk("ras_oldest_gone", bus.ras_top, 32'h0);
        chk("ras_match_cnt", bus.ras_mispred_cnt, 32'h1);
        drive(NPC_JALR, 32'h0, 32'h500);
        tick();
        chk("ras_empty_pop_cnt", bus.ras_mispred_cnt, 32'h1);
        chk("ras_empty_pop_pc", bus.pc, 32'h500);
        bus.is_ret = 0;
        bus.is_call = 1;
        drive(NPC_JUMP, 32'h10, 32'h0);
        tick();
        chk("ras_push_top", bus.ras_top, 32'h504);
        bus.is_ret = 1;
        drive(NPC_JALR, 32'h0, 32'h504);
        tick();
        chk("ras_replace_top", bus.ras_top, 32'h514);
        chk("ras_replace_cnt", bus.ras_mispred_cnt, 32'h1);
        bus.is_ret = 0;
        bus.stall = 1;
        drive(NPC_JUMP, 32'h10, 32'h0);
        tick();
        bus.stall = 0;
        bus.is_call = 0;
        chk("ras_stall_frozen", bus.ras_top, 32'h514);
`else
        bus.is_call = 1;
        drive(NPC_JUMP, 32'h10, 32'h0);
        tick();
        bus.is_call = 0;
        chk("noras_top", bus.ras_top, 32'h0);
        bus.is_ret = 1;
        drive(NPC_JALR, 32'h0, 32'h99C);
        tick();
        bus.is_ret = 0;
        chk("noras_cnt", bus.ras_mispred_cnt, 32'h0);
        chk("noras_pc", bus.pc, 32'h99C);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/npc_seq.md
Name: npc_seq

Overview:
- Parametrised, registered next-PC generator for the RISC-V core.
- Replaces the combinational next-PC/PC pair with one block that owns the PC register and computes the target from the NPC operation code.
- Adds stall hold, halt/resume, misaligned-target trapping with a saved EPC, and an external trap redirect.
- Sits between control/regfile outputs and instruction-memory address.

Parameters:
XLEN, 32, address/data width of PC, imm, rs1.
RESET_VEC, 32'h0000_0000, PC value loaded on reset.
TRAP_VEC, 32'h0000_0100, PC loaded on misalign or external trap.
RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2); used only with NPC_RAS_EN.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-high reset
stall  in  1  hold PC and state this cycle
halt  in  1  enter HALT state
resume  in  1  leave HALT state
trap_req  in  1  external trap request
npc_op  in  3  next-PC operation code
imm  in  XLEN  sign-extended immediate
rs1  in  XLEN  R[rs1] for JALR
is_call  in  1  current instr is a call (rd==x1); RAS hint
is_ret  in  1  current instr is a return (jalr x0,0(x1)); RAS hint
pc  out  XLEN  current PC to instruction memory
pc_valid  out  1  pc holds a fetchable address (state RUN)
misalign  out  1  one-cycle pulse: computed target not 4-byte aligned
epc  out  XLEN  PC of the instruction that trapped
ras_top  out  XLEN  RAS prediction (0 when feature absent)
ras_mispred_cnt  out  32  return mispredict count (0 when feature absent)

Behaviour:
- Reset (async, any state): pc=RESET_VEC, state=BOOT, epc=0, misalign=0, RAS empty, counter=0, pc_valid=0.
- States: BOOT, RUN, TRAP, HALT.
  - BOOT -> RUN after one cycle, pc unchanged.
  - RUN -> TRAP on misaligned target or trap_req.
  - TRAP -> RUN after one cycle, loading pc=TRAP_VEC.
  - RUN -> HALT on halt.
  - HALT -> RUN on resume; pc unchanged.
- pc_valid=1 only in RUN.
- Targets, all modulo 2^XLEN (wrap silently):
  - NPC_PLUS4 3'b000: pc+4.
  - NPC_BRANCH 3'b001: pc+imm.
  - NPC_JUMP 3'b010: pc+imm.
  - NPC_JALR 3'b100: (rs1+imm) & ~1.
  - Any other code: pc+4.
- In RUN, not stalled: pc <= target on the next edge (one-cycle latency).
- Priority in RUN: trap_req > halt > stall > misalign check > normal update.
- Misalign: target[1:0]!=0.
  - pc is not loaded.
  - epc <= pc.
  - misalign pulses in the same cycle the target is presented.
  - state goes to TRAP.
- trap_req: epc <= pc, state goes to TRAP; misalign is not pulsed.
- stall=1 in RUN: pc, epc and RAS are frozen; misalign is suppressed.
- stall, npc_op and the RAS hints are ignored in BOOT, TRAP and HALT.
- halt and resume asserted together in HALT: resume wins.

Optional Feature:
NPC_RAS_EN
- Defined: circular return address stack of RAS_DEPTH entries, updated only on an accepted RUN update.
  - is_call pushes pc+4.
  - Push when full overwrites the oldest entry.
  - is_ret pops. Pop when empty: no change, and no compare.
  - is_call and is_ret together: pop then push, i.e. top replaced by pc+4.
  - ras_top = top entry, or 0 when empty.
  - On is_ret with a non-empty stack, if the popped entry != JALR target, ras_mispred_cnt increments (saturating at 2^32-1).
  - The RAS is informational only: the architectural target is always the computed one.
- Undefined: no RAS storage; ras_top=0, ras_mispred_cnt=0; is_call and is_ret ignored.

Decomposition:
- Shared package/include holds:
  - NPC_* op codes (existing values, JALR=3'b100).
  - State encodings BOOT=2'd0, RUN=2'd1, TRAP=2'd2, HALT=2'd3.
  - Default RESET_VEC and TRAP_VEC.
- One natural sub-module: npc_ras (circular stack; push/pop/top/empty/full), instantiated only under NPC_RAS_EN.

Test Plan:
- Reset then 3 clocks of PLUS4: pc sequence is 0 (BOOT, pc_valid=0), 0, 4, 8; pc_valid=1 from the second cycle.
- pc=0x10, BRANCH imm=0xFFFFFFF8: pc becomes 0x08. pc=0xFFFFFFFC, PLUS4: pc wraps to 0x0.
- pc=0x20, JALR rs1=0x103, imm=0: target 0x102, misaligned. Expect misalign pulse, epc=0x20, TRAP, then pc=0x100 and RUN.
- stall held 3 cycles with JUMP imm=0x40 at pc=0x8: pc stays 0x8. After release pc=0x48. A simultaneous trap_req while stalled: epc=0x8, then pc=0x100.
- halt at pc=0x30: pc_valid=0 and pc stays 0x30 until resume. Then PLUS4 gives 0x34. Also assert rst mid-HALT: pc=0, BOOT immediately (async).
- NPC_RAS_EN, RAS_DEPTH=4:
  - 5 calls from pc 0x0,0x10,0x20,0x30,0x40: ras_top=0x44 and the oldest entry is overwritten.
  - A return whose JALR target is 0x99C instead of 0x44: ras_mispred_cnt=1.
  - Pop with the stack empty: counter unchanged.
